// File: rtl/pulse_saw_voice_pkg.sv
// pulse_saw_voice_pkg
//   Shared definitions for the pulse/saw synthesizer voice:
//   waveform-select encodings and the default widths that the voice,
//   its bus interface and the amplitude downscaler all agree on.
package pulse_saw_voice_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_PULSE = 2'd1,
        WAVE_AND   = 2'd2,
        WAVE_OFF   = 2'd3
    } wave_sel_e;

    localparam int DEF_FREQ_BITS        = 16;
    localparam int DEF_ACCUMULATOR_BITS = 24;
    localparam int DEF_OUTPUT_BITS      = 16;
    localparam int DEF_PULSEWIDTH_BITS  = 12;
    localparam int DEF_AMPLITUDE_BITS   = 8;

endpackage : pulse_saw_voice_pkg

// File: rtl/pulse_saw_voice_if.sv
// pulse_saw_voice_if
//   Control and sample bus of one synthesizer voice.
//   master : note/level controller (drives enable, freq, wave_sel,
//            pulse_width, amplitude; receives sound_data, sound_valid)
//   slave  : the voice itself
interface pulse_saw_voice_if
    import pulse_saw_voice_pkg::*;
#(
    parameter int FREQ_BITS       = DEF_FREQ_BITS,
    parameter int OUTPUT_BITS     = DEF_OUTPUT_BITS,
    parameter int PULSEWIDTH_BITS = DEF_PULSEWIDTH_BITS,
    parameter int AMPLITUDE_BITS  = DEF_AMPLITUDE_BITS
);

    logic                       enable;
    logic [FREQ_BITS-1:0]       freq;
    logic [1:0]                 wave_sel;
    logic [PULSEWIDTH_BITS-1:0] pulse_width;
    logic [AMPLITUDE_BITS-1:0]  amplitude;
    logic [OUTPUT_BITS-1:0]     sound_data;
    logic                       sound_valid;

    modport master (
        output enable,
        output freq,
        output wave_sel,
        output pulse_width,
        output amplitude,
        input  sound_data,
        input  sound_valid
    );

    modport slave (
        input  enable,
        input  freq,
        input  wave_sel,
        input  pulse_width,
        input  amplitude,
        output sound_data,
        output sound_valid
    );

endinterface : pulse_saw_voice_if

// File: rtl/pulse_saw_voice_amplitude_downscaler.sv
// amplitude_downscaler
//   Combinational level control: dout = (din * amplitude) >> AMPLITUDE_BITS,
//   truncated (no rounding). Full-scale amplitude therefore gives
//   din * (2^AMPLITUDE_BITS - 1) / 2^AMPLITUDE_BITS, never exactly din.
//   Ports:
//     din       in  DATA_BITS       unsigned sample
//     amplitude in  AMPLITUDE_BITS  unsigned level
//     dout      out DATA_BITS       scaled sample
module amplitude_downscaler #(
    parameter int DATA_BITS      = 16,
    parameter int AMPLITUDE_BITS = 8
) (
    input  logic [DATA_BITS-1:0]      din,
    input  logic [AMPLITUDE_BITS-1:0] amplitude,
    output logic [DATA_BITS-1:0]      dout
);

    localparam int PROD_BITS = DATA_BITS + AMPLITUDE_BITS;

    function automatic logic [DATA_BITS-1:0] scale_trunc(
        input logic [DATA_BITS-1:0]      d,
        input logic [AMPLITUDE_BITS-1:0] a
    );
        logic [PROD_BITS-1:0] prod;
        prod = PROD_BITS'(d) * PROD_BITS'(a);
        return DATA_BITS'(prod >> AMPLITUDE_BITS);
    endfunction

    assign dout = scale_trunc(din, amplitude);

endmodule : amplitude_downscaler

// File: rtl/pulse_saw_voice.sv
// pulse_saw_voice
//   One synthesizer voice: phase accumulator -> saw / pulse extraction ->
//   waveform select -> amplitude downscaler -> registered sample.
//   One sample per clock; a sample reflects the accumulator value held
//   before the edge that registers it.
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous reset, active-high (clears phase and output)
//     bus  slave modport of pulse_saw_voice_if
//          enable, freq, wave_sel, pulse_width, amplitude in;
//          sound_data, sound_valid out (both registered)
module pulse_saw_voice
    import pulse_saw_voice_pkg::*;
#(
    parameter int FREQ_BITS        = DEF_FREQ_BITS,
    parameter int ACCUMULATOR_BITS = DEF_ACCUMULATOR_BITS,
    parameter int OUTPUT_BITS      = DEF_OUTPUT_BITS,
    parameter int PULSEWIDTH_BITS  = DEF_PULSEWIDTH_BITS,
    parameter int AMPLITUDE_BITS   = DEF_AMPLITUDE_BITS
) (
    input  logic               clk,
    input  logic               rst,
    pulse_saw_voice_if.slave   bus
);

    logic [ACCUMULATOR_BITS-1:0] acc_p0;
    logic [OUTPUT_BITS-1:0]      saw;
    logic [PULSEWIDTH_BITS-1:0]  phase_top;
    logic [OUTPUT_BITS-1:0]      pulse;
    logic [OUTPUT_BITS-1:0]      raw;
    logic [OUTPUT_BITS-1:0]      scaled;
    logic [OUTPUT_BITS-1:0]      data_p1;
    logic                        vld_p1;

    // ---- stage p0: phase accumulator (wraps, carry discarded) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0 <= '0;
        end else if (bus.enable) begin
            acc_p0 <= acc_p0 + ACCUMULATOR_BITS'(bus.freq);
        end
    end

    // Waveforms are taken from the top of the phase; the pulse compares
    // only the top PULSEWIDTH_BITS, so pulse_width=0 never fires and the
    // all-ones bucket is always low even at maximum width.
    assign saw       = acc_p0[ACCUMULATOR_BITS-1 -: OUTPUT_BITS];
    assign phase_top = acc_p0[ACCUMULATOR_BITS-1 -: PULSEWIDTH_BITS];
    assign pulse     = (phase_top < bus.pulse_width) ? '1 : '0;

    always_comb begin
        raw = '0;
        unique case (wave_sel_e'(bus.wave_sel))
            WAVE_SAW:   raw = saw;
            WAVE_PULSE: raw = pulse;
            WAVE_AND:   raw = saw & pulse;
            WAVE_OFF:   raw = '0;
            default:    raw = '0;
        endcase
    end

    amplitude_downscaler #(
        .DATA_BITS      (OUTPUT_BITS),
        .AMPLITUDE_BITS (AMPLITUDE_BITS)
    ) u_downscaler (
        .din       (raw),
        .amplitude (bus.amplitude),
        .dout      (scaled)
    );

    // ---- stage p1: output sample register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            data_p1 <= scaled;
            vld_p1  <= bus.enable;
        end
    end

    assign bus.sound_data  = data_p1;
    assign bus.sound_valid = vld_p1;

endmodule : pulse_saw_voice

// File: tb/tb_pulse_saw_voice.sv
// tb_pulse_saw_voice
//   Directed bench for pulse_saw_voice: a table of stimulus records with
//   hand-computed expected samples, followed by longer sequences for the
//   ramp, duty-cycle, select, enable and reset behaviour.
module tb_pulse_saw_voice;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pulse_saw_voice_if bus ();

    pulse_saw_voice dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic [15:0] freq;
        logic [1:0]  sel;
        logic [11:0] pw;
        logic [7:0]  amp;
        int          ncyc;
        logic [15:0] exp_data;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act_d,
                         input logic [15:0] exp_d, input logic act_v,
                         input logic exp_v);
        total++;
        if (act_d !== exp_d || act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got data=%h valid=%b, want data=%h valid=%b",
                     name, act_d, act_v, exp_d, exp_v);
        end
    endtask

    // Advance n rising edges, then move to the falling edge to sample.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic en, input logic [15:0] f,
                         input logic [1:0] sel, input logic [11:0] pw,
                         input logic [7:0] amp);
        rst             = r;
        bus.enable      = en;
        bus.freq        = f;
        bus.wave_sel    = sel;
        bus.pulse_width = pw;
        bus.amplitude   = amp;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 16'h0, 2'd0, 12'h0, 8'h0);
        tick(1);
    endtask

    initial begin
        logic [15:0] exp_d;
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 16'h0, 2'd0, 12'h0, 8'h0);

        //            name           rst  en   freq      sel   pw       amp    n    data      valid
        vecs.push_back('{"reset_en",   1'b1,1'b1,16'h1000,2'd0,12'h800,8'h80,  2, 16'h0000,1'b0});
        vecs.push_back('{"pulse_hi0",  1'b0,1'b1,16'h8000,2'd1,12'h800,8'hFF,  1, 16'hFEFF,1'b1});
        vecs.push_back('{"hold_pulse", 1'b0,1'b0,16'h8000,2'd1,12'h800,8'hFF,  1, 16'hFEFF,1'b0});
        vecs.push_back('{"amp_ef",     1'b0,1'b0,16'h8000,2'd1,12'h800,8'hEF,  1, 16'hEEFF,1'b0});
        vecs.push_back('{"amp_00",     1'b0,1'b0,16'h8000,2'd1,12'h800,8'h00,  1, 16'h0000,1'b0});
        vecs.push_back('{"amp_80",     1'b0,1'b0,16'h8000,2'd1,12'h800,8'h80,  1, 16'h7FFF,1'b0});
        vecs.push_back('{"pw_zero",    1'b0,1'b0,16'h8000,2'd1,12'h000,8'hFF,  1, 16'h0000,1'b0});
        vecs.push_back('{"sel_off",    1'b0,1'b0,16'h8000,2'd3,12'h800,8'hFF,  1, 16'h0000,1'b0});
        vecs.push_back('{"and_lo",     1'b0,1'b0,16'h8000,2'd2,12'h800,8'hFF,  1, 16'h007F,1'b0});
        vecs.push_back('{"saw_lo",     1'b0,1'b0,16'h8000,2'd0,12'h800,8'hFF,  1, 16'h007F,1'b0});
        vecs.push_back('{"pulse_half", 1'b0,1'b1,16'h8000,2'd1,12'h800,8'hFF,256, 16'h0000,1'b1});
        vecs.push_back('{"and_hi",     1'b0,1'b0,16'h8000,2'd2,12'h800,8'hFF,  1, 16'h0000,1'b0});
        vecs.push_back('{"saw_hi",     1'b0,1'b0,16'h8000,2'd0,12'h800,8'hFF,  1, 16'h7FFF,1'b0});
        vecs.push_back('{"pw_above",   1'b0,1'b0,16'h8000,2'd1,12'h809,8'hFF,  1, 16'hFEFF,1'b0});
        vecs.push_back('{"pw_equal",   1'b0,1'b0,16'h8000,2'd1,12'h808,8'hFF,  1, 16'h0000,1'b0});
        vecs.push_back('{"pw_max",     1'b0,1'b0,16'h8000,2'd1,12'hFFF,8'hFF,  1, 16'hFEFF,1'b0});
        vecs.push_back('{"sel_off2",   1'b0,1'b0,16'h8000,2'd3,12'hFFF,8'hFF,  1, 16'h0000,1'b0});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].freq, vecs[i].sel,
                  vecs[i].pw, vecs[i].amp);
            tick(vecs[i].ncyc);
            check(vecs[i].name, bus.sound_data, vecs[i].exp_data,
                  bus.sound_valid, vecs[i].exp_valid);
        end

        // Saw ramp: +8 per sample at amplitude 0x80, wraps after 4096.
        do_reset();
        drive(1'b0, 1'b1, 16'h1000, 2'd0, 12'h800, 8'h80);
        for (int k = 0; k < 4100; k++) begin
            tick(1);
            exp_d = 16'((k % 4096) * 8);
            check($sformatf("saw_ramp[%0d]", k), bus.sound_data, exp_d,
                  bus.sound_valid, 1'b1);
        end

        // 50% pulse at full amplitude.
        do_reset();
        drive(1'b0, 1'b1, 16'h1000, 2'd1, 12'h800, 8'hFF);
        for (int k = 0; k < 8192; k++) begin
            tick(1);
            exp_d = ((k % 4096) < 2048) ? 16'hFEFF : 16'h0000;
            check($sformatf("pulse50[%0d]", k), bus.sound_data, exp_d,
                  bus.sound_valid, 1'b1);
        end

        // Maximum pulse width: only the 0xFFF phase bucket is low.
        do_reset();
        drive(1'b0, 1'b1, 16'h1000, 2'd1, 12'hFFF, 8'hFF);
        for (int k = 0; k < 4097; k++) begin
            tick(1);
            exp_d = ((k % 4096) == 4095) ? 16'h0000 : 16'hFEFF;
            check($sformatf("pw_fff[%0d]", k), bus.sound_data, exp_d,
                  bus.sound_valid, 1'b1);
        end

        // Zero pulse width: constant silence.
        do_reset();
        drive(1'b0, 1'b1, 16'h1000, 2'd1, 12'h000, 8'hFF);
        for (int k = 0; k < 64; k++) begin
            tick(1);
            check($sformatf("pw_0[%0d]", k), bus.sound_data, 16'h0000,
                  bus.sound_valid, 1'b1);
        end

        // Saw AND 50% pulse: saw in first half period, zero in second.
        do_reset();
        drive(1'b0, 1'b1, 16'h1000, 2'd2, 12'h800, 8'hFF);
        for (int k = 0; k < 4096; k++) begin
            tick(1);
            exp_d = (k < 2048) ? 16'((k * 16 * 255) / 256) : 16'h0000;
            check($sformatf("and50[%0d]", k), bus.sound_data, exp_d,
                  bus.sound_valid, 1'b1);
        end

        // Enable drop mid-ramp, then reset with enable high.
        do_reset();
        drive(1'b0, 1'b1, 16'h1000, 2'd0, 12'h800, 8'h80);
        tick(10);
        check("ramp_pre_drop", bus.sound_data, 16'h0048, bus.sound_valid, 1'b1);
        bus.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check($sformatf("frozen[%0d]", k), bus.sound_data, 16'h0050,
                  bus.sound_valid, 1'b0);
        end
        bus.amplitude = 8'h40;
        tick(1);
        check("frozen_amp40", bus.sound_data, 16'h0028, bus.sound_valid, 1'b0);
        bus.amplitude = 8'h80;
        bus.enable    = 1'b1;
        tick(3);
        check("resumed", bus.sound_data, 16'h0060, bus.sound_valid, 1'b1);
        rst = 1'b1;
        tick(1);
        check("mid_reset", bus.sound_data, 16'h0000, bus.sound_valid, 1'b0);
        rst = 1'b0;
        tick(1);
        check("restart0", bus.sound_data, 16'h0000, bus.sound_valid, 1'b1);
        tick(1);
        check("restart1", bus.sound_data, 16'h0008, bus.sound_valid, 1'b1);
        tick(1);
        check("restart2", bus.sound_data, 16'h0010, bus.sound_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pulse_saw_voice
